// File: rtl/ysyx_25030085_imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030085_imem_pkg
// Purpose  : Shared types and constants for the instruction-memory responder:
//            FSM state encoding, default base address and LFSR seed/taps.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25030085_imem_pkg;

    // Responder FSM states; the encoding is fixed so traces read consistently
    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_t;

    // Byte address of RAM word 0 (the core's reset vector region)
    localparam logic [31:0] c_imem_base_addr = 32'h8000_0000;

    // Fibonacci LFSR seed and tap mask (taps 16,14,13,11 -> bits 15,13,12,10)
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    // Wait counter width: covers LAT (0..15) plus up to 3 random extra cycles
    localparam int unsigned c_cnt_w = 5;

    // Feedback bit for the Fibonacci LFSR: XOR of all tapped bits
    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & c_lfsr_taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25030085_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030085_lfsr16
// Purpose  : Free-running 16-bit Fibonacci LFSR, synchronously reset to the
//            package seed. Steps on every rising clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030085_lfsr16
    import ysyx_25030085_imem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    logic [15:0] r_lfsr;

    // Shift left, inserting the tap feedback at bit 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= c_lfsr_seed;
        end else begin
            r_lfsr <= {r_lfsr[14:0], lfsr_feedback(r_lfsr)};
        end
    end

    assign o_state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/ysyx_25030085_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030085_imem_responder
// Purpose  : Memory end of the core's fetch interface. Accepts a PC over a
//            valid/ready request channel, waits a programmable number of
//            cycles, then returns the instruction word (or an access fault)
//            over a valid/ready response channel. The RAM is preloaded via a
//            dedicated write port that may be used in any state.
// Options  : IMEM_RAND_DELAY_EN - adds 0..3 pseudo-random wait cycles per
//            access using a 16-bit LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030085_imem_responder
    import ysyx_25030085_imem_pkg::*;
#(
    parameter  int unsigned DEPTH     = 1024,
    parameter  logic [31:0] BASE_ADDR = c_imem_base_addr,
    parameter  int unsigned LAT       = 2,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    // Fetch request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    // Fetch response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    // Preload write port
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [31:0]       wr_data
);

    // 33-bit window bounds so BASE_ADDR + 4*DEPTH cannot wrap
    localparam logic [32:0] c_win_lo = {1'b0, BASE_ADDR};
    localparam logic [32:0] c_win_hi = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

    imem_state_t         r_state;
    imem_state_t         w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [31:0]         r_addr;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_err;
    logic [31:0]         r_mem [DEPTH];

    logic [1:0]          w_extra;
    logic [c_cnt_w-1:0]  w_total_lat;
    logic                w_req_fire;
    logic                w_do_read;
    logic [31:0]         w_rd_addr;
    logic [ADDR_W-1:0]   w_rd_idx;
    logic                w_rd_err;

`ifdef IMEM_RAND_DELAY_EN
    logic [15:0] w_lfsr;

    ysyx_25030085_lfsr16 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    assign w_extra = w_lfsr[1:0];
`else
    assign w_extra = 2'd0;
`endif

    // Total wait cycles for the request being accepted this cycle
    assign w_total_lat = c_cnt_w'(LAT) + c_cnt_w'(w_extra);

    assign w_req_fire = req_valid && (r_state == IMEM_IDLE);

    // RAM read happens on the edge that enters RESP: directly at acceptance
    // for zero latency, otherwise on the last WAIT edge
    assign w_do_read = (w_req_fire && (w_total_lat == '0)) ||
                       ((r_state == IMEM_WAIT) && (r_cnt == c_cnt_w'(1)));

    // In IDLE the read can only be the zero-latency case, so use the live PC
    assign w_rd_addr = (r_state == IMEM_IDLE) ? req_addr : r_addr;
    assign w_rd_idx  = ADDR_W'((w_rd_addr - BASE_ADDR) >> 2);
    assign w_rd_err  = (w_rd_addr[1:0] != 2'b00) ||
                       ({1'b0, w_rd_addr} <  c_win_lo) ||
                       ({1'b0, w_rd_addr} >= c_win_hi);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IMEM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IMEM_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = (w_total_lat == '0) ? IMEM_RESP : IMEM_WAIT;
                end
            end
            IMEM_WAIT: begin
                if (r_cnt == c_cnt_w'(1)) begin
                    w_state_nxt = IMEM_RESP;
                end
            end
            IMEM_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = IMEM_IDLE;
                end
            end
            default: begin
                w_state_nxt = IMEM_IDLE;
            end
        endcase
    end

    // Address latch, wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (w_req_fire) begin
                r_addr <= req_addr;
                r_cnt  <= w_total_lat;
            end else if (r_state == IMEM_WAIT) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            // Captured once per access; held untouched through RESP so later
            // preload writes cannot disturb a pending response
            if (w_do_read) begin
                r_rsp_err  <= w_rd_err;
                r_rsp_data <= w_rd_err ? 32'd0 : r_mem[w_rd_idx];
            end
        end
    end

    // Preload write port; a same-edge read above sees the old word
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

endmodule
`default_nettype wire

// File: doc/ysyx_25030085_imem_responder.md
Name: ysyx_25030085_imem_responder

Overview:
Instruction-memory responder: the memory end of the core's fetch interface. The core presents a PC; this block returns the instruction word.
- Request and response each use a valid/ready handshake.
- Internal word-addressed RAM, preloaded through a dedicated write port.
- Access latency is programmable, so a bench can model slow memory before the core moves to a multi-cycle fetch.

Parameters:
- DEPTH, 1024, RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- LAT, 2, extra wait cycles per access; legal range 0..15.
- ADDR_W, clog2(DEPTH), derived localparam; not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address (the PC).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  requester accepts the response.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  access fault: misaligned or out of range.
- wr_en  in  1  preload write enable.
- wr_addr  in  ADDR_W  preload word index.
- wr_data  in  32  preload data.

Behaviour:
- Reset values:
  - state IDLE, wait counter 0, latched address 0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - req_ready=1, since it is asserted only in IDLE.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_addr.
  - LAT==0: go to RESP.
  - LAT>0: go to WAIT with counter=LAT.
  - req_valid without a handshake has no effect.
- WAIT:
  - req_ready=0; counter decrements each edge.
  - When counter==1, the next edge performs the RAM read and enters RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until handshake.
  - On rsp_valid&&rsp_ready, go to IDLE; rsp_valid deasserts the next cycle.
  - req_ready=0, so no new request is accepted in the same cycle as a response handshake.
- Latency and throughput:
  - If the request handshake is in cycle N, rsp_valid is first high in cycle N+1+LAT.
  - Minimum period per fetch with rsp_ready held high: LAT+2 cycles.
- Address decode, word index = (req_addr-BASE_ADDR)>>2:
  - req_addr[1:0]!=0 gives rsp_err=1, rsp_data=0.
  - req_addr<BASE_ADDR or req_addr>=BASE_ADDR+4*DEPTH gives rsp_err=1, rsp_data=0.
  - Otherwise rsp_err=0 and rsp_data=RAM[index].
- Preload write:
  - Takes effect at the edge where wr_en=1; allowed in any state.
  - A write to the word being read at the same edge returns the old data (read-before-write).
  - A write after the read edge does not alter a held rsp_data.
- Reset mid-operation: any pending request or response is dropped. The block is in IDLE with rsp_valid=0 in the cycle after reset.
- Address arithmetic: 32-bit unsigned with no wrap. The range check uses 33-bit compares so that BASE_ADDR+4*DEPTH cannot overflow.

Optional Feature:
- Macro: IMEM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (seed 16'hACE1 at reset) steps every cycle.
  - At request acceptance, its low 2 bits are added to LAT as extra wait cycles (0..3).
  - The WAIT entry condition becomes LAT+extra>0.
  - The response ordering and stability rules are unchanged.
- Undefined: latency is exactly LAT; no LFSR is instantiated.

Decomposition:
- Shared package ysyx_25030085_imem_pkg:
  - State encoding constants IMEM_IDLE=2'd0, IMEM_WAIT=2'd1, IMEM_RESP=2'd2.
  - Default BASE_ADDR constant.
  - LFSR seed and taps constant (16'hACE1, taps 16,14,13,11).
- Sub-module ysyx_25030085_lfsr16: free-running LFSR with synchronous reset to the seed. It is instantiated only under IMEM_RAND_DELAY_EN.

Test Plan:
- Preload RAM[0]=32'h00000413, LAT=2, request 32'h8000_0000 with rsp_ready=1:
  - rsp_valid is first high 3 cycles after the handshake cycle.
  - rsp_data=32'h00000413, rsp_err=0, req_ready=0 throughout.
- LAT=0, five back-to-back fetches 0x8000_0000..0x8000_0010:
  - Each response arrives 1 cycle after its request.
  - One fetch completes every 2 cycles, with data in order.
- Request 32'h8000_0002 (misaligned) and 32'h8000_1000 (DEPTH=1024, out of range):
  - Both return rsp_err=1, rsp_data=0.
- Backpressure: hold rsp_ready=0 for 6 cycles, and write RAM[0]=32'hDEADBEEF during RESP:
  - rsp_valid stays 1 and rsp_data keeps the old word.
  - Handshake on the first cycle with rsp_ready=1, then IDLE.
- Assert rst in WAIT, then request again:
  - rsp_valid=0 and req_ready=1 in the cycle after reset.
  - The new request completes normally; preloaded data is intact.
- Same-edge write and read of word 4 (old 32'h11111111, new 32'h22222222):
  - The response returns 32'h11111111.
  - A following fetch of the same address returns 32'h22222222.
